// File: rtl/pat_pkg.sv
// pat_pkg: shared definitions for the pat sequencer slice.
//   - Fault code values reported on fault_code_o.
//   - Op-select enum produced by the strobe decoder.
//   - STACK_WRAP_EN: set when PAT_SEQ_STACK_WRAP_EN is defined. In that build the call
//     stack is circular, and a call on a full stack drops the oldest entry.
package pat_pkg;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_OVF   = 2'd1;
    localparam logic [1:0] FAULT_UNF   = 2'd2;
    localparam logic [1:0] FAULT_MULTI = 2'd3;

    typedef enum logic [2:0] {
        OP_STEP = 3'd0,
        OP_BF   = 3'd1,
        OP_BB   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_sel_e;

`ifdef PAT_SEQ_STACK_WRAP_EN
    localparam bit STACK_WRAP_EN = 1'b1;
`else
    localparam bit STACK_WRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/pat_call_stack.sv
// pat_call_stack: LIFO return-address stack.
//   Storage is a ring buffer. wr_ptr_q is the next free slot, and the top of the stack is
//   the slot before it. In the non-wrap build, a push on a full stack is dropped. In the
//   PAT_SEQ_STACK_WRAP_EN build, that push overwrites the oldest entry and depth stays
//   at DEPTH.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         push push_data_i (ignored if pop_i is also set)
//   pop_i          drop the top entry (caller guarantees not empty)
//   push_data_i    address to push
//   top_o          top-of-stack, 0 when empty
//   depth_o        live entries 0..DEPTH
//   full_o/empty_o depth == DEPTH / depth == 0
module pat_call_stack
    import pat_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int ADR_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [ADR_W-1:0] push_data_i,
    output logic [ADR_W-1:0] top_o,
    output logic [PTR_W:0]   depth_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [ADR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   depth_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (depth_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    // Explicit wrap keeps the ring correct for non-power-of-two depths.
    assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr     = (wr_ptr_q == '0) ? PTR_W'(DEPTH - 1) : wr_ptr_q - 1'b1;

    assign push_ok = push_i && !pop_i && (!full_o || STACK_WRAP_EN);
    assign pop_ok  = pop_i && !push_i && !empty_o;

    assign top_o = empty_o ? '0 : mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
        end else if (push_ok) begin
            wr_ptr_q <= wr_ptr_inc;
            if (!full_o) begin
                depth_q <= depth_q + 1'b1;
            end
        end else if (pop_ok) begin
            wr_ptr_q <= rd_ptr;
            depth_q  <= depth_q - 1'b1;
        end
    end

    // Contents are not reset. An entry is only readable while depth covers it, and
    // reset clears depth.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pat_sequencer.sv
// pat_sequencer: PC and call/return sequencing for the pat core.
//   Handles step, relative forward/back branches, absolute call and return.
//   Condition gating and stall are supported.
//   Faults are sticky and record only the first one. Once set, all state freezes until reset.
//   Macro PAT_SEQ_STACK_WRAP_EN selects a circular call stack with no overflow fault.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en_i              1 = execute op, 0 = stall
//   cond_ok_i         0 turns any strobe into a plain step
//   op_bf_i/op_bb_i   relative branch forward/back by zext(offset_i)
//   op_call_i         push pc+1, jump to call_target_i
//   op_return_i       pop and jump to the popped address
//   pc_o              current PC
//   ret_adr_o         top of stack (0 when empty)
//   depth_o           live stack entries
//   stack_full_o, stack_empty_o
//   fault_o, fault_code_o   sticky fault flag and first fault code
module pat_sequencer
    import pat_pkg::*;
#(
    parameter int                    I_ADR_WIDTH     = 10,
    parameter int                    OFFSET_WIDTH    = 8,
    parameter int                    STACK_DEPTH     = 8,
    parameter int                    STACK_PTR_WIDTH = 3,
    parameter logic [I_ADR_WIDTH-1:0] RESET_VECTOR   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       cond_ok_i,
    input  logic                       op_bf_i,
    input  logic                       op_bb_i,
    input  logic                       op_call_i,
    input  logic                       op_return_i,
    input  logic [OFFSET_WIDTH-1:0]    offset_i,
    input  logic [I_ADR_WIDTH-1:0]     call_target_i,
    output logic [I_ADR_WIDTH-1:0]     pc_o,
    output logic [I_ADR_WIDTH-1:0]     ret_adr_o,
    output logic [STACK_PTR_WIDTH:0]   depth_o,
    output logic                       stack_full_o,
    output logic                       stack_empty_o,
    output logic                       fault_o,
    output logic [1:0]                 fault_code_o
);

    logic [I_ADR_WIDTH-1:0] pc_q, pc_d;
    logic                   fault_q, fault_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic [2:0]             strobe_cnt;
    logic                   multi_strobe;
    op_sel_e                op_sel;
    logic                   push, pop;
    logic [I_ADR_WIDTH-1:0] top;
    logic                   full, empty;

    // Strobe decode. Multiple strobes only matter when the condition passes.
    always_comb begin
        strobe_cnt   = {2'b00, op_bf_i} + {2'b00, op_bb_i}
                     + {2'b00, op_call_i} + {2'b00, op_return_i};
        multi_strobe = cond_ok_i && (strobe_cnt > 3'd1);
        op_sel       = OP_STEP;
        if (cond_ok_i && strobe_cnt == 3'd1) begin
            if (op_bf_i)        op_sel = OP_BF;
            else if (op_bb_i)   op_sel = OP_BB;
            else if (op_call_i) op_sel = OP_CALL;
            else                op_sel = OP_RET;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        push         = 1'b0;
        pop          = 1'b0;
        if (en_i && !fault_q) begin
            if (multi_strobe) begin
                fault_d      = 1'b1;
                fault_code_d = FAULT_MULTI;
            end else begin
                case (op_sel)
                    OP_BF:   pc_d = pc_q + I_ADR_WIDTH'(offset_i);
                    OP_BB:   pc_d = pc_q - I_ADR_WIDTH'(offset_i);
                    OP_CALL: begin
                        if (full && !STACK_WRAP_EN) begin
                            fault_d      = 1'b1;
                            fault_code_d = FAULT_OVF;
                        end else begin
                            push = 1'b1;
                            pc_d = call_target_i;
                        end
                    end
                    OP_RET: begin
                        if (empty) begin
                            fault_d      = 1'b1;
                            fault_code_d = FAULT_UNF;
                        end else begin
                            pop  = 1'b1;
                            pc_d = top;
                        end
                    end
                    default: pc_d = pc_q + 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    pat_call_stack #(
        .DEPTH (STACK_DEPTH),
        .PTR_W (STACK_PTR_WIDTH),
        .ADR_W (I_ADR_WIDTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_q + 1'b1),
        .top_o       (top),
        .depth_o     (depth_o),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign pc_o          = pc_q;
    assign ret_adr_o     = top;
    assign stack_full_o  = full;
    assign stack_empty_o = empty;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;

endmodule
